mem_port_arbiter: RTL and testbench

- Arbitrates the single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each access over a fixed memory latency and returns read data to the winning stage.
- Generates the per-stage stall signals that hold the PC and pipeline registers while a request is pending.

---
 rtl/mem_port_arbiter_pkg.sv | 33 +++
 rtl/mem_port_arbiter_lat.sv | 29 ++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Holds the FSM encoding, latency bounds, counter width and grant helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

    // Picks the next busy state from the pending requests. On a tie the
    // port that was not served last wins, so the two stages alternate.
    function automatic arb_state_t arb_pick(
        input logic i_pend,
        input logic d_pend,
        input logic last_d
    );
        arb_state_t s;
        s = IDLE;
        unique case (1'b1)
            (i_pend & d_pend):  s = last_d ? BUSY_I : BUSY_D;
            (d_pend & ~i_pend): s = BUSY_D;
            (i_pend & ~d_pend): s = BUSY_I;
            default:            s = IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lat.sv
// lat_counter: loadable down-counter with a terminal-count flag.
// Ports: clk, rst (async, active-high), load/load_val, en, count, tc (count==1).
module lat_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between IF and MEM stages.
// Ports: clk, rst; IF side if_req/if_addr/if_done/if_rdata/stall_if;
//   MEM side d_rd/d_wr/d_addr/d_wdata/d_done/d_rdata/stall_mem;
//   memory side m_addr/m_re/m_we/m_wdata (registered) and m_rdata.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_re,
    output logic              m_we,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    arb_state_t        grant;
    logic              last_d;
    logic              is_wr;
    logic              issue;
    logic              d_pend;
    logic              strobe;
    logic              acc_done;
    logic              done_i;
    logic              done_d;
    logic              ld_done;
    logic [CNT_W-1:0]  cnt;
    logic              tc;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] d_hold;

    assign d_pend = d_rd | d_wr;
    assign grant  = arb_pick(if_req, d_pend, last_d);
    assign strobe = m_re | m_we;

    // The counter holds its loaded value while the strobe is out, so it
    // reaches 1 exactly MEM_LAT cycles after the strobe cycle.
    lat_counter #(
        .W (CNT_W)
    ) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (issue),
        .load_val (CNT_W'(MEM_LAT)),
        .en       ((state != IDLE) && !strobe),
        .count    (cnt),
        .tc       (tc)
    );

    assign acc_done = (state != IDLE) && tc && !strobe;
    assign done_i   = (state == BUSY_I) && acc_done;
    assign done_d   = (state == BUSY_D) && acc_done;
    assign ld_done  = done_d && !is_wr;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = grant;
                issue     = (grant != IDLE);
            end
            BUSY_I, BUSY_D: begin
                if (acc_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            is_wr   <= 1'b0;
            m_re    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            if_hold <= '0;
            d_hold  <= '0;
        end else begin
            state <= state_nxt;
            m_re  <= 1'b0;
            m_we  <= 1'b0;
            if (issue) begin
                if (state_nxt == BUSY_I) begin
                    m_addr <= if_addr;
                    m_re   <= 1'b1;
                    is_wr  <= 1'b0;
                end else begin
                    m_addr <= d_addr;
                    is_wr  <= d_wr;
                    if (d_wr) begin
                        m_we    <= 1'b1;
                        m_wdata <= d_wdata;
                    end else begin
                        m_re <= 1'b1;
                    end
                end
            end
            if (acc_done) begin
                last_d <= (state == BUSY_D);
            end
            if (done_i) begin
                if_hold <= m_rdata;
            end
            if (ld_done) begin
                d_hold <= m_rdata;
            end
        end
    end

    // Read data is forwarded in the done cycle and held afterwards.
    assign if_done   = done_i;
    assign if_rdata  = done_i ? m_rdata : if_hold;
    assign d_done    = done_d;
    assign d_rdata   = ld_done ? m_rdata : d_hold;
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = d_pend & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with MEM_LAT 1, 2 and 3 instances.
// Each instance has a memory model that returns data MEM_LAT cycles after m_re.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] if_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic [2:0]       if_done_a;
    logic [2:0]       d_done_a;
    logic [2:0]       stall_if_a;
    logic [2:0]       stall_mem_a;
    logic [2:0]       m_re_a;
    logic [2:0]       m_we_a;
    logic [2:0][31:0] if_rdata_a;
    logic [2:0][31:0] d_rdata_a;
    logic [2:0][31:0] m_addr_a;
    logic [2:0][31:0] m_wdata_a;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h4) return 32'h0050_0093;
        return {16'hC0DE, a[15:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic        if_done;
        logic        d_done;
        logic        stall_if;
        logic        stall_mem;
        logic        m_re;
        logic        m_we;
        logic [31:0] if_rdata;
        logic [31:0] d_rdata;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [31:0] m_rdata;
        logic [3:0]  sh;

        mem_port_arbiter #(
            .ADDR_W  (32),
            .DATA_W  (32),
            .MEM_LAT (g + 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_done   (if_done),
            .if_rdata  (if_rdata),
            .d_rd      (d_rd),
            .d_wr      (d_wr),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_done    (d_done),
            .d_rdata   (d_rdata),
            .stall_if  (stall_if),
            .stall_mem (stall_mem),
            .m_addr    (m_addr),
            .m_re      (m_re),
            .m_we      (m_we),
            .m_wdata   (m_wdata),
            .m_rdata   (m_rdata)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) sh <= '0;
            else     sh <= {sh[2:0], m_re};
        end

        assign m_rdata = sh[g] ? rom(m_addr) : 32'hBAD0_BAD0;

        assign if_done_a[g]   = if_done;
        assign d_done_a[g]    = d_done;
        assign stall_if_a[g]  = stall_if;
        assign stall_mem_a[g] = stall_mem;
        assign m_re_a[g]      = m_re;
        assign m_we_a[g]      = m_we;
        assign if_rdata_a[g]  = if_rdata;
        assign d_rdata_a[g]   = d_rdata;
        assign m_addr_a[g]    = m_addr;
        assign m_wdata_a[g]   = m_wdata;
    end

    typedef struct {
        logic        ifr;
        logic [31:0] ia;
        logic        drd;
        logic        dwr;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        idn;
        logic        ddn;
        logic        sif;
        logic        smem;
        logic        re;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [31:0] ird;
        logic [31:0] drdat;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0;
        d_rd    = 1'b0;
        d_wr    = 1'b0;
        if_addr = '0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    task automatic chk_regs_zero(input int k, input string tag);
        chk({tag, " m_re"},     32'(m_re_a[k]), 32'h0);
        chk({tag, " m_we"},     32'(m_we_a[k]), 32'h0);
        chk({tag, " if_done"},  32'(if_done_a[k]), 32'h0);
        chk({tag, " d_done"},   32'(d_done_a[k]), 32'h0);
        chk({tag, " m_addr"},   m_addr_a[k], 32'h0);
        chk({tag, " m_wdata"},  m_wdata_a[k], 32'h0);
        chk({tag, " if_rdata"}, if_rdata_a[k], 32'h0);
        chk({tag, " d_rdata"},  d_rdata_a[k], 32'h0);
    endtask

    task automatic do_reset(input logic check);
        rst = 1'b1;
        idle_inputs();
        sample();
        if (check) begin
            for (int k = 0; k < 3; k++) chk_regs_zero(k, "reset");
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                    32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                    32'h4, 32'h0, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h4, 32'h0, 32'h0050_0093, 32'h0};
        tbl[3]  = '{1'b1, 32'h8, 1'b1, 1'b0, 32'h100, 32'h0,
                    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                    32'h4, 32'h0, 32'h0050_0093, 32'h0};
        tbl[4]  = '{1'b1, 32'h8, 1'b1, 1'b0, 32'h100, 32'h0,
                    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                    32'h100, 32'h0, 32'h0050_0093, 32'h0};
        tbl[5]  = '{1'b1, 32'h8, 1'b1, 1'b0, 32'h100, 32'h0,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    32'h100, 32'h0, 32'h0050_0093, 32'hC0DE_0100};
        tbl[6]  = '{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                    32'h100, 32'h0, 32'h0050_0093, 32'hC0DE_0100};
        tbl[7]  = '{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                    32'h8, 32'h0, 32'h0050_0093, 32'hC0DE_0100};
        tbl[8]  = '{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h8, 32'h0, 32'hC0DE_0008, 32'hC0DE_0100};
        tbl[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h8, 32'h0, 32'hC0DE_0008, 32'hC0DE_0100};
        tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                    32'h8, 32'h0, 32'hC0DE_0008, 32'hC0DE_0100};
        tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                    32'h200, 32'hDEAD_BEEF, 32'hC0DE_0008, 32'hC0DE_0100};
        tbl[12] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h200, 32'hDEAD_BEEF, 32'hC0DE_0008, 32'hC0DE_0100};
        tbl[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    32'h200, 32'hDEAD_BEEF, 32'hC0DE_0008, 32'hC0DE_0100};

        idle_inputs();
        #1;

        // Table: fetch, simultaneous D/I, store on the MEM_LAT=1 instance.
        do_reset(1'b1);
        for (int i = 0; i < 14; i++) begin
            tick();
            if_req  = tbl[i].ifr;
            if_addr = tbl[i].ia;
            d_rd    = tbl[i].drd;
            d_wr    = tbl[i].dwr;
            d_addr  = tbl[i].da;
            d_wdata = tbl[i].dwd;
            sample();
            chk($sformatf("v%0d if_done", i),   32'(if_done_a[0]), 32'(tbl[i].idn));
            chk($sformatf("v%0d d_done", i),    32'(d_done_a[0]), 32'(tbl[i].ddn));
            chk($sformatf("v%0d stall_if", i),  32'(stall_if_a[0]), 32'(tbl[i].sif));
            chk($sformatf("v%0d stall_mem", i), 32'(stall_mem_a[0]), 32'(tbl[i].smem));
            chk($sformatf("v%0d m_re", i),      32'(m_re_a[0]), 32'(tbl[i].re));
            chk($sformatf("v%0d m_we", i),      32'(m_we_a[0]), 32'(tbl[i].we));
            chk($sformatf("v%0d m_addr", i),    m_addr_a[0], tbl[i].maddr);
            chk($sformatf("v%0d m_wdata", i),   m_wdata_a[0], tbl[i].mwd);
            chk($sformatf("v%0d if_rdata", i),  if_rdata_a[0], tbl[i].ird);
            chk($sformatf("v%0d d_rdata", i),   d_rdata_a[0], tbl[i].drdat);
        end

        // Reset mid-access on the MEM_LAT=3 instance.
        do_reset(1'b0);
        tick();
        if_req  = 1'b1;
        if_addr = 32'h40;
        sample();
        chk("rst_mid pre m_re", 32'(m_re_a[2]), 32'h0);
        tick();
        sample();
        chk("rst_mid issue m_re", 32'(m_re_a[2]), 32'h1);
        chk("rst_mid issue m_addr", m_addr_a[2], 32'h40);
        tick();
        rst = 1'b1;
        sample();
        chk_regs_zero(2, "rst_mid");
        for (int c = 0; c < 3; c++) begin
            tick();
            sample();
            chk("rst_mid held if_done", 32'(if_done_a[2]), 32'h0);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            sample();
            chk($sformatf("rst_re c%0d if_done", c),
                32'(if_done_a[2]), 32'(c == 4));
            chk($sformatf("rst_re c%0d m_re", c),
                32'(m_re_a[2]), 32'(c == 1));
            if (c == 4) chk("rst_re if_rdata", if_rdata_a[2], 32'hC0DE_0040);
        end
        if_req = 1'b0;

        // Load then store on the MEM_LAT=2 instance.
        do_reset(1'b0);
        tick();
        d_rd   = 1'b1;
        d_addr = 32'h100;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            sample();
            chk($sformatf("ld2 c%0d d_done", c), 32'(d_done_a[1]), 32'(c == 3));
            chk($sformatf("ld2 c%0d m_re", c), 32'(m_re_a[1]), 32'(c == 1));
            if (c == 3) chk("ld2 d_rdata", d_rdata_a[1], 32'hC0DE_0100);
        end
        tick();
        d_rd    = 1'b0;
        d_wr    = 1'b1;
        d_addr  = 32'h200;
        d_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            sample();
            chk($sformatf("st2 c%0d m_we", c), 32'(m_we_a[1]), 32'(c == 1));
            chk($sformatf("st2 c%0d m_re", c), 32'(m_re_a[1]), 32'h0);
            chk($sformatf("st2 c%0d d_done", c), 32'(d_done_a[1]), 32'(c == 3));
            chk($sformatf("st2 c%0d d_rdata", c), d_rdata_a[1], 32'hC0DE_0100);
            if (c == 1) begin
                chk("st2 m_addr", m_addr_a[1], 32'h200);
                chk("st2 m_wdata", m_wdata_a[1], 32'hDEAD_BEEF);
            end
            if (c == 3) d_wr = 1'b0;
        end

        // Sustained contention on the MEM_LAT=1 instance: D,I,D,I every 3.
        do_reset(1'b0);
        tick();
        if_req  = 1'b1;
        d_rd    = 1'b1;
        if_addr = 32'h10;
        d_addr  = 32'h20;
        for (int c = 0; c < 21; c++) begin
            if (c > 0) tick();
            sample();
            chk($sformatf("alt c%0d d_done", c), 32'(d_done_a[0]),
                32'((c % 3 == 2) && ((c / 3) % 2 == 0)));
            chk($sformatf("alt c%0d if_done", c), 32'(if_done_a[0]),
                32'((c % 3 == 2) && ((c / 3) % 2 == 1)));
            chk($sformatf("alt c%0d stall_if", c), 32'(stall_if_a[0]),
                32'(!((c % 3 == 2) && ((c / 3) % 2 == 1))));
        end
        idle_inputs();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
